// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the two-requester DMA AXI read arbiter.
package dma_arb_pkg;

  localparam int unsigned REQ_NUM = 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Field widths are upper bounds; the arbiter uses the low ID_W/ADDR_W bits.
  localparam int unsigned AR_ID_MAX_W   = 16;
  localparam int unsigned AR_ADDR_MAX_W = 64;

  typedef struct packed {
    logic [AR_ID_MAX_W-1:0]   id;
    logic [AR_ADDR_MAX_W-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } ar_req_t;

  function automatic int unsigned cnt_width(input int unsigned max_outs);
    return $clog2(max_outs + 1);
  endfunction

endpackage

// File: rtl/dma_arb_outs_cnt.sv
// Per-requester outstanding-burst counter with limit flag and underflow detect.
module dma_arb_outs_cnt
  import dma_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTS = 8,
  localparam int unsigned CNT_W = cnt_width(MAX_OUTS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_limit,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_inc && !i_dec) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end else if (!i_inc && i_dec && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_cnt       = r_cnt;
  assign o_at_limit  = (r_cnt >= CNT_W'(MAX_OUTS));
  assign o_underflow = i_dec && (r_cnt == '0);

endmodule

// File: rtl/dma_axi_rd_arb.sv
// Round-robin AXI4 read arbiter sharing one DMA AR/R path between two requesters.
// Optional performance counters are enabled by defining DMA_ARB_PERF_EN.
module dma_axi_rd_arb
  import dma_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 36,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned MAX_OUTS = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ID_W-2:0]   m0_ar_id,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic [7:0]        m0_ar_len,
  input  logic [2:0]        m0_ar_size,
  input  logic [1:0]        m0_ar_burst,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [ID_W-2:0]   m0_r_id,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,

  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ID_W-2:0]   m1_ar_id,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic [7:0]        m1_ar_len,
  input  logic [2:0]        m1_ar_size,
  input  logic [1:0]        m1_ar_burst,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [ID_W-2:0]   m1_r_id,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,

  output logic              s_dma_ar_valid,
  input  logic              s_dma_ar_ready,
  output logic [ID_W-1:0]   s_dma_ar_id,
  output logic [ADDR_W-1:0] s_dma_ar_addr,
  output logic [7:0]        s_dma_ar_len,
  output logic [2:0]        s_dma_ar_size,
  output logic [1:0]        s_dma_ar_burst,

  input  logic              s_dma_r_valid,
  output logic              s_dma_r_ready,
  input  logic [ID_W-1:0]   s_dma_r_id,
  input  logic [DATA_W-1:0] s_dma_r_data,
  input  logic [1:0]        s_dma_r_resp,
  input  logic              s_dma_r_last,

  output logic              err_underflow
`ifdef DMA_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTS);

  logic [REQ_NUM-1:0] w_elig, w_gnt, w_inc, w_dec, w_at_limit, w_underflow;
  logic [CNT_W-1:0]   w_cnt0, w_cnt1;
  ar_req_t            w_req0, w_req1;
  logic               w_slot_free, w_r_sel, w_r_done;

  ar_req_t            r_slot;
  logic               r_slot_valid;
  logic               r_rr;
  logic               r_err;

  // Requester index is carried in the downstream ID MSB.
  always_comb begin
    w_req0                  = '0;
    w_req0.id[ID_W-1:0]     = {1'b0, m0_ar_id};
    w_req0.addr[ADDR_W-1:0] = m0_ar_addr;
    w_req0.len              = m0_ar_len;
    w_req0.size             = m0_ar_size;
    w_req0.burst            = m0_ar_burst;
    w_req1                  = '0;
    w_req1.id[ID_W-1:0]     = {1'b1, m1_ar_id};
    w_req1.addr[ADDR_W-1:0] = m1_ar_addr;
    w_req1.len              = m1_ar_len;
    w_req1.size             = m1_ar_size;
    w_req1.burst            = m1_ar_burst;
  end

  assign w_elig      = {m1_ar_valid & ~w_at_limit[1], m0_ar_valid & ~w_at_limit[0]};
  assign w_slot_free = !r_slot_valid || s_dma_ar_ready;

  always_comb begin
    w_gnt = '0;
    if (w_slot_free) begin
      if (&w_elig) begin
        w_gnt[r_rr] = 1'b1;
      end else begin
        w_gnt = w_elig;
      end
    end
  end

  assign m0_ar_ready = w_gnt[0];
  assign m1_ar_ready = w_gnt[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot_valid <= 1'b0;
      r_slot       <= '0;
      r_rr         <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_slot_valid <= |w_gnt;
        if (w_gnt[1]) begin
          r_slot <= w_req1;
        end else if (w_gnt[0]) begin
          r_slot <= w_req0;
        end
      end
      if (|w_gnt) begin
        r_rr <= w_gnt[0];
      end
    end
  end

  assign s_dma_ar_valid = r_slot_valid;
  assign s_dma_ar_id    = r_slot.id[ID_W-1:0];
  assign s_dma_ar_addr  = r_slot.addr[ADDR_W-1:0];
  assign s_dma_ar_len   = r_slot.len;
  assign s_dma_ar_size  = r_slot.size;
  assign s_dma_ar_burst = r_slot.burst;

  logic unused_slot_hi;
  assign unused_slot_hi = ^{r_slot.id[AR_ID_MAX_W-1:ID_W], r_slot.addr[AR_ADDR_MAX_W-1:ADDR_W]};

  assign w_r_sel       = s_dma_r_id[ID_W-1];
  assign m0_r_valid    = s_dma_r_valid & ~w_r_sel;
  assign m1_r_valid    = s_dma_r_valid & w_r_sel;
  assign s_dma_r_ready = w_r_sel ? m1_r_ready : m0_r_ready;
  assign m0_r_id       = s_dma_r_id[ID_W-2:0];
  assign m1_r_id       = s_dma_r_id[ID_W-2:0];
  assign m0_r_data     = s_dma_r_data;
  assign m1_r_data     = s_dma_r_data;
  assign m0_r_resp     = s_dma_r_resp;
  assign m1_r_resp     = s_dma_r_resp;
  assign m0_r_last     = s_dma_r_last;
  assign m1_r_last     = s_dma_r_last;

  assign w_r_done = s_dma_r_valid & s_dma_r_ready & s_dma_r_last;
  assign w_dec    = {w_r_done & w_r_sel, w_r_done & ~w_r_sel};
  assign w_inc    = {m1_ar_valid & w_gnt[1], m0_ar_valid & w_gnt[0]};

  dma_arb_outs_cnt #(
    .MAX_OUTS (MAX_OUTS)
  ) u_cnt0 (
    .clock       (clock),
    .reset       (reset),
    .i_inc       (w_inc[0]),
    .i_dec       (w_dec[0]),
    .o_cnt       (w_cnt0),
    .o_at_limit  (w_at_limit[0]),
    .o_underflow (w_underflow[0])
  );

  dma_arb_outs_cnt #(
    .MAX_OUTS (MAX_OUTS)
  ) u_cnt1 (
    .clock       (clock),
    .reset       (reset),
    .i_inc       (w_inc[1]),
    .i_dec       (w_dec[1]),
    .o_cnt       (w_cnt1),
    .o_at_limit  (w_at_limit[1]),
    .o_underflow (w_underflow[1])
  );

  logic [2*CNT_W-1:0] unused_cnt;
  assign unused_cnt = {w_cnt1, w_cnt0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (|w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign err_underflow = r_err;

`ifdef DMA_ARB_PERF_EN
  logic [31:0] r_perf_grant0, r_perf_grant1, r_perf_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_grant0 <= '0;
      r_perf_grant1 <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_inc[0]) r_perf_grant0 <= r_perf_grant0 + 32'd1;
      if (w_inc[1]) r_perf_grant1 <= r_perf_grant1 + 32'd1;
      if (r_slot_valid && !s_dma_ar_ready) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_grant0 = r_perf_grant0;
  assign perf_grant1 = r_perf_grant1;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_dma_axi_rd_arb.sv
// Directed self-checking bench for dma_axi_rd_arb (default parameters, MAX_OUTS=8).
module tb_dma_axi_rd_arb;
  import dma_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [2:0]   m0_ar_id, m1_ar_id, m0_r_id, m1_r_id;
  logic [35:0]  m0_ar_addr, m1_ar_addr, s_dma_ar_addr;
  logic [7:0]   m0_ar_len, m1_ar_len, s_dma_ar_len;
  logic [2:0]   m0_ar_size, m1_ar_size, s_dma_ar_size;
  logic [1:0]   m0_ar_burst, m1_ar_burst, s_dma_ar_burst;
  logic         m0_r_valid, m0_r_ready, m1_r_valid, m1_r_ready;
  logic [255:0] m0_r_data, m1_r_data, s_dma_r_data;
  logic [1:0]   m0_r_resp, m1_r_resp, s_dma_r_resp;
  logic         m0_r_last, m1_r_last, s_dma_r_last;
  logic         s_dma_ar_valid, s_dma_ar_ready;
  logic [3:0]   s_dma_ar_id, s_dma_r_id;
  logic         s_dma_r_valid, s_dma_r_ready;
  logic         err_underflow;
`ifdef DMA_ARB_PERF_EN
  logic [31:0]  perf_grant0, perf_grant1, perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dma_axi_rd_arb dut (
    .clock(clock), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_id(m0_ar_id),
    .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len), .m0_ar_size(m0_ar_size),
    .m0_ar_burst(m0_ar_burst), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m0_r_id(m0_r_id), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_id(m1_ar_id),
    .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len), .m1_ar_size(m1_ar_size),
    .m1_ar_burst(m1_ar_burst), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .m1_r_id(m1_r_id), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
    .s_dma_ar_valid(s_dma_ar_valid), .s_dma_ar_ready(s_dma_ar_ready),
    .s_dma_ar_id(s_dma_ar_id), .s_dma_ar_addr(s_dma_ar_addr), .s_dma_ar_len(s_dma_ar_len),
    .s_dma_ar_size(s_dma_ar_size), .s_dma_ar_burst(s_dma_ar_burst),
    .s_dma_r_valid(s_dma_r_valid), .s_dma_r_ready(s_dma_r_ready), .s_dma_r_id(s_dma_r_id),
    .s_dma_r_data(s_dma_r_data), .s_dma_r_resp(s_dma_r_resp), .s_dma_r_last(s_dma_r_last),
    .err_underflow(err_underflow)
`ifdef DMA_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_valid = 0; m0_ar_id = '0; m0_ar_addr = '0; m0_ar_len = '0;
    m0_ar_size = '0; m0_ar_burst = '0; m0_r_ready = 0;
    m1_ar_valid = 0; m1_ar_id = '0; m1_ar_addr = '0; m1_ar_len = '0;
    m1_ar_size = '0; m1_ar_burst = '0; m1_r_ready = 0;
    s_dma_ar_ready = 0; s_dma_r_valid = 0; s_dma_r_id = '0;
    s_dma_r_data = '0; s_dma_r_resp = '0; s_dma_r_last = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    tick();
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    tick();
    n_tests++;
    if ({s_dma_ar_valid, m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, s_dma_r_ready}
        !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got 0 mismatch on ready/valid bits %b",
        {s_dma_ar_valid, m0_ar_ready, m1_ar_ready, m0_r_valid, m1_r_valid, s_dma_r_ready});
    end
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b expected 0", err_underflow);
    end
    n_tests++;
    if ({dut.w_cnt0, dut.w_cnt1} !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt: got %h expected 00", {dut.w_cnt0, dut.w_cnt1});
    end
    tick();
    reset = 1;
  endtask

  task automatic test_single();
    logic [255:0] exp_data;
    do_reset();
    s_dma_ar_ready = 1;
    m0_ar_valid = 1; m0_ar_id = 3'h5; m0_ar_addr = 36'h0_8000_0000;
    m0_ar_len = 8'd3; m0_ar_size = 3'd5; m0_ar_burst = BURST_INCR;
    #1;
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready, s_dma_ar_valid} !== 3'b100) begin
      n_fail++; $display("FAIL single_grant: got %b expected 100",
        {m0_ar_ready, m1_ar_ready, s_dma_ar_valid});
    end
    tick();
    m0_ar_valid = 0;
    n_tests++;
    if ({s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr, s_dma_ar_len, s_dma_ar_burst} !==
        {1'b1, 4'h5, 36'h0_8000_0000, 8'd3, BURST_INCR}) begin
      n_fail++; $display("FAIL single_slot: got v=%b id=%h addr=%h len=%0d burst=%0d",
        s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr, s_dma_ar_len, s_dma_ar_burst);
    end
    n_tests++;
    if (dut.w_cnt0 !== 4'd1) begin
      n_fail++; $display("FAIL single_cnt_inc: got %0d expected 1", dut.w_cnt0);
    end
    tick();
    n_tests++;
    if (s_dma_ar_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_slot_drain: got %b expected 0", s_dma_ar_valid);
    end
    m0_r_ready = 1; s_dma_r_valid = 1; s_dma_r_id = 4'h5;
    for (int b = 0; b < 4; b++) begin
      exp_data = 256'(b) + 256'h100;
      s_dma_r_data = exp_data; s_dma_r_last = (b == 3);
      #1;
      n_tests++;
      if ({m0_r_valid, m1_r_valid, s_dma_r_ready, m0_r_id, m0_r_data} !==
          {3'b101, 3'h5, exp_data}) begin
        n_fail++; $display("FAIL single_r_beat%0d: got v0=%b v1=%b rdy=%b id=%h data=%h", b,
          m0_r_valid, m1_r_valid, s_dma_r_ready, m0_r_id, m0_r_data[15:0]);
      end
      tick();
    end
    s_dma_r_valid = 0; s_dma_r_last = 0; m0_r_ready = 0;
    n_tests++;
    if (dut.w_cnt0 !== 4'd0) begin
      n_fail++; $display("FAIL single_cnt_dec: got %0d expected 0", dut.w_cnt0);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    s_dma_ar_ready = 1;
    m0_ar_valid = 1; m0_ar_id = 3'h1;
    m1_ar_valid = 1; m1_ar_id = 3'h2;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({m0_ar_ready, m1_ar_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL fair_grant%0d: got %b%b", i, m0_ar_ready, m1_ar_ready);
      end
      tick();
      if (i == 7) begin
        m0_ar_valid = 0; m1_ar_valid = 0;
      end
      n_tests++;
      if (s_dma_ar_id !== ((i % 2 == 0) ? 4'h1 : 4'hA)) begin
        n_fail++; $display("FAIL fair_id%0d: got %h expected %h", i, s_dma_ar_id,
          (i % 2 == 0) ? 4'h1 : 4'hA);
      end
    end
    n_tests++;
    if ({dut.w_cnt0, dut.w_cnt1} !== 8'h44) begin
      n_fail++; $display("FAIL fair_cnt: got %h expected 44", {dut.w_cnt0, dut.w_cnt1});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m0_ar_valid = 1; m0_ar_id = 3'h3; m0_ar_addr = 36'h0_0000_00A0; m0_ar_len = 8'd7;
    m1_ar_valid = 1; m1_ar_id = 3'h4; m1_ar_addr = 36'h0_0000_00B0; m1_ar_len = 8'd1;
    #1;
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_first: got %b%b expected 10", m0_ar_ready, m1_ar_ready);
    end
    tick();
    m0_ar_addr = 36'h0_0000_00C0;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if ({m0_ar_ready, m1_ar_ready, s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr, s_dma_ar_len}
          !== {3'b001, 4'h3, 36'h0_0000_00A0, 8'd7}) begin
        n_fail++; $display("FAIL bp_hold%0d: got rdy=%b%b v=%b id=%h addr=%h", c,
          m0_ar_ready, m1_ar_ready, s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr);
      end
      tick();
    end
    s_dma_ar_ready = 1;
    #1;
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release: got %b%b expected 01", m0_ar_ready, m1_ar_ready);
    end
    tick();
    m0_ar_valid = 0; m1_ar_valid = 0;
    n_tests++;
    if ({s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr} !== {1'b1, 4'hC, 36'h0_0000_00B0}) begin
      n_fail++; $display("FAIL bp_next: got v=%b id=%h addr=%h expected 1 c b0",
        s_dma_ar_valid, s_dma_ar_id, s_dma_ar_addr);
    end
  endtask

  task automatic test_limit();
    do_reset();
    s_dma_ar_ready = 1;
    m0_ar_valid = 1; m0_ar_id = 3'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (m0_ar_ready !== 1'b1) begin
        n_fail++; $display("FAIL limit_fill%0d: got %b expected 1", i, m0_ar_ready);
      end
      tick();
    end
    n_tests++;
    if (dut.w_cnt0 !== 4'd8) begin
      n_fail++; $display("FAIL limit_cnt: got %0d expected 8", dut.w_cnt0);
    end
    m1_ar_valid = 1; m1_ar_id = 3'h6;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if ({m0_ar_ready, m1_ar_ready} !== 2'b01) begin
        n_fail++; $display("FAIL limit_block%0d: got %b%b expected 01", i, m0_ar_ready,
          m1_ar_ready);
      end
      tick();
    end
    m0_r_ready = 1; s_dma_r_valid = 1; s_dma_r_id = 4'h0; s_dma_r_last = 1;
    #1;
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready} !== 2'b01) begin
      n_fail++; $display("FAIL limit_lastcyc: got %b%b expected 01", m0_ar_ready, m1_ar_ready);
    end
    tick();
    s_dma_r_valid = 0; s_dma_r_last = 0;
    #1;
    n_tests++;
    if ({m0_ar_ready, m1_ar_ready, dut.w_cnt0} !== {2'b10, 4'd7}) begin
      n_fail++; $display("FAIL limit_regrant: got rdy=%b%b cnt=%0d expected 10 cnt 7",
        m0_ar_ready, m1_ar_ready, dut.w_cnt0);
    end
    tick();
    m0_ar_valid = 0; m1_ar_valid = 0; m0_r_ready = 0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    s_dma_ar_ready = 1;
    m1_ar_valid = 1; m1_ar_id = 3'h1;
    tick();
    m1_r_ready = 1; s_dma_r_valid = 1; s_dma_r_id = 4'h9; s_dma_r_last = 1;
    #1;
    n_tests++;
    if ({m1_ar_ready, m1_r_valid, m0_r_valid, s_dma_r_ready, m1_r_id} !== {4'b1101, 3'h1})
    begin
      n_fail++; $display("FAIL same_route: got ar=%b v1=%b v0=%b rdy=%b id=%h",
        m1_ar_ready, m1_r_valid, m0_r_valid, s_dma_r_ready, m1_r_id);
    end
    tick();
    m1_ar_valid = 0; s_dma_r_last = 0;
    n_tests++;
    if (dut.w_cnt1 !== 4'd1) begin
      n_fail++; $display("FAIL same_cnt: got %0d expected 1", dut.w_cnt1);
    end
    m1_r_ready = 0; m0_r_ready = 1;
    #1;
    n_tests++;
    if ({s_dma_r_ready, m1_r_valid} !== 2'b01) begin
      n_fail++; $display("FAIL same_ready_follow: got rdy=%b v1=%b expected 0 1",
        s_dma_r_ready, m1_r_valid);
    end
    s_dma_r_valid = 0; m0_r_ready = 0;
  endtask

  task automatic test_underflow();
    do_reset();
    m0_r_ready = 1; s_dma_r_valid = 1; s_dma_r_id = 4'h2; s_dma_r_last = 1;
    #1;
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL uf_before: got %b expected 0", err_underflow);
    end
    tick();
    s_dma_r_valid = 0; s_dma_r_last = 0;
    n_tests++;
    if ({err_underflow, dut.w_cnt0} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL uf_set: got err=%b cnt=%0d expected 1 0", err_underflow,
        dut.w_cnt0);
    end
    tick();
    n_tests++;
    if (err_underflow !== 1'b1) begin
      n_fail++; $display("FAIL uf_sticky: got %b expected 1", err_underflow);
    end
  endtask

  task automatic test_async_reset();
    m0_ar_valid = 1; m0_ar_id = 3'h2; m0_ar_addr = 36'h1_2345_6780;
    tick();
    #2;
    reset = 0;
    clear_inputs();
    #1;
    n_tests++;
    if ({s_dma_ar_valid, err_underflow, m0_ar_ready, dut.w_cnt0} !== {3'b000, 4'd0}) begin
      n_fail++; $display("FAIL async_reset: got v=%b err=%b rdy=%b cnt=%0d expected all 0",
        s_dma_ar_valid, err_underflow, m0_ar_ready, dut.w_cnt0);
    end
    tick();
    reset = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_limit();
    test_same_cycle();
    test_underflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
